// File: rtl/vga_tile_pkg.sv
// Shared definitions for the VGA tile painter.
// Provides the default active-area geometry and colour width, the clear-sweep
// FSM state type, and a clog2 helper that never returns less than 1 so that
// it can be used directly as a vector width.
package vga_tile_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned ColorWDef  = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  // Width needed to hold values 0..n-1, with a minimum of 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_tile_painter_if.sv
// Signal bundle between the tile painter and its surroundings.
//   master: drives x/y/in_display, colour, paint/clear and move pulses;
//           receives pixel, cursor_idx and busy.
//   slave : the painter itself.
interface vga_tile_painter_if #(
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned IDX_W   = 3
);
  logic [9:0]         x;
  logic [9:0]         y;
  logic               in_display;
  logic [COLOR_W-1:0] color_in;
  logic               paint;
  logic               clear;
  logic               mv_left;
  logic               mv_right;
  logic               mv_up;
  logic               mv_down;
  logic [COLOR_W-1:0] pixel;
  logic [IDX_W-1:0]   cursor_idx;
  logic               busy;

  modport master (
    output x, y, in_display, color_in, paint, clear, mv_left, mv_right, mv_up, mv_down,
    input  pixel, cursor_idx, busy
  );

  modport slave (
    input  x, y, in_display, color_in, paint, clear, mv_left, mv_right, mv_up, mv_down,
    output pixel, cursor_idx, busy
  );
endinterface

// File: rtl/vga_blink_timer.sv
// Free-running blink timer.
//   clk, rst : clock and asynchronous active-high reset
//   phase_o  : toggles every BLINK_HALF cycles (starts at 0)
//   wrap_o   : one-cycle pulse on the last count of each phase
module vga_blink_timer
  import vga_tile_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 4000000
) (
  input  logic clk,
  input  logic rst,
  output logic phase_o,
  output logic wrap_o
);
  localparam int unsigned CntW = clog2_min1(BLINK_HALF);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    wrap_o  = (cnt_q == CntW'(BLINK_HALF - 1));
    cnt_d   = wrap_o ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ wrap_o;
    phase_o = phase_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/vga_tile_painter.sv
// Tile-colour painter for the 640x480 VGA path.
// The screen is split into TILES_X x TILES_Y tiles of COLOR_W-bit colour. A
// cursor selects one tile; paint stores color_in there, clear sweeps all tiles
// to 0 one per cycle. The cursor tile blinks between the live colour and its
// stored colour. Pixel output is registered, two clocks after x/y.
// Ports: clk, rst (async, active-high), bus (vga_tile_painter_if.slave).
// Optional: define TILE_PAINTER_CURSOR_XOR_EN to show the inverted stored
// colour in blink phase 1 instead of the plain stored colour.
module vga_tile_painter
  import vga_tile_pkg::*;
#(
  parameter int unsigned TILES_X    = 4,
  parameter int unsigned TILES_Y    = 2,
  parameter int unsigned COLOR_W    = ColorWDef,
  parameter int unsigned H_ACTIVE   = HActiveDef,
  parameter int unsigned V_ACTIVE   = VActiveDef,
  parameter int unsigned BLINK_HALF = 4000000
) (
  input logic              clk,
  input logic              rst,
  vga_tile_painter_if.slave bus
);
  localparam int unsigned NumTiles = TILES_X * TILES_Y;
  localparam int unsigned IdxW     = clog2_min1(NumTiles);
  localparam int unsigned ColW     = clog2_min1(TILES_X);
  localparam int unsigned RowW     = clog2_min1(TILES_Y);
  localparam int unsigned TileW    = H_ACTIVE / TILES_X;
  localparam int unsigned TileH    = V_ACTIVE / TILES_Y;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    sweep_q, sweep_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [COLOR_W-1:0] tiles_q [NumTiles];
  logic [COLOR_W-1:0] tiles_d [NumTiles];
  logic [IdxW-1:0]    s1_idx_q, s1_idx_d;
  logic               s1_inside_q, s1_inside_d;
  logic               s1_de_q, s1_de_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic [IdxW-1:0]    cur_idx;
  logic [31:0]        x_w, y_w;
  int unsigned        tile_col, tile_row;
  logic [COLOR_W-1:0] stored;
  logic               blink_phase;

  vga_blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .phase_o(blink_phase),
    .wrap_o ()
  );

  assign cur_idx = IdxW'(32'(row_q) * TILES_X + 32'(col_q));

  // Stage 1: tile lookup by constant compare chain.
  always_comb begin
    x_w      = 32'(bus.x);
    y_w      = 32'(bus.y);
    tile_col = 0;
    tile_row = 0;
    for (int unsigned c = 1; c < TILES_X; c++) begin
      if (x_w >= c * TileW) tile_col = c;
    end
    for (int unsigned r = 1; r < TILES_Y; r++) begin
      if (y_w >= r * TileH) tile_row = r;
    end
    s1_idx_d    = IdxW'(tile_row * TILES_X + tile_col);
    s1_inside_d = (x_w < TILES_X * TileW) && (y_w < TILES_Y * TileH);
    s1_de_d     = bus.in_display;
  end

  // Stage 2: colour select with cursor blink.
  always_comb begin
    stored  = tiles_q[s1_idx_q];
    pixel_d = '0;
    if (s1_de_q && s1_inside_q) begin
      if (s1_idx_q == cur_idx) begin
`ifdef TILE_PAINTER_CURSOR_XOR_EN
        pixel_d = blink_phase ? ~stored : bus.color_in;
`else
        pixel_d = blink_phase ? stored : bus.color_in;
`endif
      end else begin
        pixel_d = stored;
      end
    end
  end

  // Control FSM: cursor moves, paint and clear sweep.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    col_d   = col_q;
    row_d   = row_q;
    tiles_d = tiles_q;
    case (state_q)
      StIdle: begin
        if (bus.clear) begin
          state_d = StClear;
          sweep_d = '0;
        end else if (bus.paint) begin
          tiles_d[cur_idx] = bus.color_in;
        end
        if (bus.mv_right && !bus.mv_left) begin
          col_d = (col_q == ColW'(TILES_X - 1)) ? '0 : col_q + 1'b1;
        end else if (bus.mv_left && !bus.mv_right) begin
          col_d = (col_q == '0) ? ColW'(TILES_X - 1) : col_q - 1'b1;
        end
        if (bus.mv_down && !bus.mv_up) begin
          row_d = (row_q == RowW'(TILES_Y - 1)) ? '0 : row_q + 1'b1;
        end else if (bus.mv_up && !bus.mv_down) begin
          row_d = (row_q == '0) ? RowW'(TILES_Y - 1) : row_q - 1'b1;
        end
      end
      StClear: begin
        tiles_d[sweep_q] = '0;
        if (sweep_q == IdxW'(NumTiles - 1)) begin
          state_d = StIdle;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s1_idx_q    <= '0;
      s1_inside_q <= 1'b0;
      s1_de_q     <= 1'b0;
      pixel_q     <= '0;
      for (int i = 0; i < NumTiles; i++) tiles_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_idx_q    <= s1_idx_d;
      s1_inside_q <= s1_inside_d;
      s1_de_q     <= s1_de_d;
      pixel_q     <= pixel_d;
      tiles_q     <= tiles_d;
    end
  end

  assign bus.pixel      = pixel_q;
  assign bus.cursor_idx = cur_idx;
  assign bus.busy       = (state_q == StClear);
endmodule
